// File: rtl/audio_pkg.sv
// Shared definitions for the I2S audio transmit path.
// Contents: clock/default localparams, FSM state type, and the
// offset-binary to two's-complement sample conversion helper.
package audio_pkg;
  localparam int CLOCK_FREQ       = 50_000_000;
  localparam int DEF_CLOCK_DIV    = 15;
  localparam int DEF_SAMPLE_WIDTH = 16;
  localparam logic [7:0] SILENCE  = 8'h80;

  typedef enum logic {IDLE, RUN} i2s_state_t;

  // Top byte of the two's-complement word; the caller left-justifies it
  // into SAMPLE_WIDTH bits.
  function automatic logic signed [7:0] to_signed_word(input logic [7:0] sample);
    return sample ^ 8'h80;
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO, power-of-2 depth, async active-high reset.
// A write while full is accepted when a pop happens in the same cycle.
// Ports: clock, reset, wr_en/wr_data, rd_en, rd_data (show-ahead), full, empty.
module sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_wr, do_rd;

  // Extra pointer MSB distinguishes full from empty.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/audio_i2s_tx.sv
// Mono I2S transmitter: buffers 8-bit offset-binary samples in a FIFO,
// converts each to a SAMPLE_WIDTH two's-complement word and sends it in
// both the left and right slots. BCLK/LRCLK are divided from clock.
// Ports: clock, reset (async, active-high), enable, sample_in/sample_valid,
//   clear_flags, i2s_bclk/i2s_lrclk/i2s_sdata, sticky overflow/underflow,
//   running (FSM in RUN).
// Option: define AUDIO_TX_ATTEN_EN to add atten[2:0], an arithmetic right
//   shift applied to the word, sampled only when a frame is loaded.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int CLOCK_DIV    = DEF_CLOCK_DIV,
  parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] sample_in,
  input  logic       sample_valid,
  input  logic       clear_flags,
`ifdef AUDIO_TX_ATTEN_EN
  input  logic [2:0] atten,
`endif
  output logic       i2s_bclk,
  output logic       i2s_lrclk,
  output logic       i2s_sdata,
  output logic       overflow,
  output logic       underflow,
  output logic       running
);
  localparam int FRAME_W = 2 * SAMPLE_WIDTH;
  localparam int CW      = $clog2(FRAME_W);
  localparam int DW      = $clog2(CLOCK_DIV + 1);

  i2s_state_t state, state_nxt;
  logic [DW-1:0]      div;
  logic [CW-1:0]      bit_cnt, next_bit, bit_idx;
  logic [FRAME_W-1:0] cur_frame;
  logic [7:0]         last_sample, fifo_dout, src_sample;
  logic               fifo_full, fifo_empty;
  logic               tc, fall, slot0, stop, pop;
  logic signed [SAMPLE_WIDTH-1:0] word, word_sh;

  sample_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (sample_valid),
    .wr_data (sample_in),
    .rd_en   (pop),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign tc       = (div == DW'(CLOCK_DIV - 1));
  assign fall     = (state == RUN) && tc && i2s_bclk;
  assign next_bit = (bit_cnt == CW'(FRAME_W - 1)) ? '0 : bit_cnt + CW'(1);
  assign slot0    = fall && (next_bit == '0);
  assign stop     = slot0 && !enable;
  assign pop      = slot0 && enable && !fifo_empty;
  // Slot b (b>=1) carries frame bit FRAME_W-b: one BCLK behind LRCLK.
  assign bit_idx  = CW'(FRAME_W - 1) - (next_bit - CW'(1));
  assign running  = (state == RUN);

  // Empty FIFO at a frame boundary repeats the previous sample.
  assign src_sample = fifo_empty ? last_sample : fifo_dout;
  assign word       = SAMPLE_WIDTH'(to_signed_word(src_sample)) <<< (SAMPLE_WIDTH - 8);
`ifdef AUDIO_TX_ATTEN_EN
  assign word_sh    = word >>> atten;
`else
  assign word_sh    = word;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (enable && !fifo_empty) state_nxt = RUN;
      RUN:  if (stop) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div         <= '0;
      i2s_bclk    <= 1'b0;
      i2s_lrclk   <= 1'b0;
      i2s_sdata   <= 1'b0;
      bit_cnt     <= CW'(FRAME_W - 1);
      cur_frame   <= '0;
      last_sample <= SILENCE;
    end else if (state == IDLE) begin
      div      <= '0;
      i2s_bclk <= 1'b0;
    end else begin
      div <= tc ? '0 : div + DW'(1);
      if (tc) i2s_bclk <= ~i2s_bclk;
      if (fall) begin
        i2s_lrclk <= (next_bit >= CW'(SAMPLE_WIDTH));
        if (!slot0) begin
          bit_cnt   <= next_bit;
          i2s_sdata <= cur_frame[bit_idx];
        end else begin
          // Right LSB of the outgoing frame; on a stop bit_cnt stays at
          // FRAME_W-1 so the next start lands on slot 0.
          i2s_sdata <= cur_frame[0];
          if (enable) begin
            bit_cnt     <= next_bit;
            last_sample <= src_sample;
            cur_frame   <= {word_sh, word_sh};
          end
        end
      end
    end
  end

  // Clear wins over a same-cycle set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear_flags) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sample_valid && fifo_full && !pop) overflow  <= 1'b1;
      if (slot0 && enable && fifo_empty)     underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_audio_i2s_tx.sv
module tb_audio_i2s_tx;
  localparam int CD = 2, SW = 16, DEPTH = 4;

  logic clock = 1'b0, reset = 1'b1, enable = 1'b0;
  logic sample_valid = 1'b0, clear_flags = 1'b0;
  logic [7:0] sample_in = 8'h80;
`ifdef AUDIO_TX_ATTEN_EN
  logic [2:0] atten = 3'd0;
`endif
  logic i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, running;

  int vectors = 0, miscompares = 0;

  always #5 clock = ~clock;

  audio_i2s_tx #(.CLOCK_DIV(CD), .SAMPLE_WIDTH(SW), .FIFO_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .clear_flags  (clear_flags),
`ifdef AUDIO_TX_ATTEN_EN
    .atten        (atten),
`endif
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .overflow     (overflow),
    .underflow    (underflow),
    .running      (running)
  );

  // ---------------- behavioural model ----------------
  // Tracks time since RUN entry, the current slot, and the two channel
  // words; the bit on the wire is derived from the slot number directly.
  bit         m_run;
  int         m_rt, m_slot;
  logic [15:0] m_lw, m_rw;
  logic       m_sd, m_lr, m_ovf, m_unf;
  logic [7:0] m_last;
  logic [7:0] m_q[$];
  logic [5:0] a_out, e_out;

  function automatic logic [15:0] exp_word(logic [7:0] s, int sh);
    logic signed [15:0] w;
    w = {s ^ 8'h80, 8'h00};
    return w >>> sh;
  endfunction

  task automatic model_reset();
    m_run = 0; m_rt = 0; m_slot = 2*SW-1; m_lw = '0; m_rw = '0;
    m_sd = 0; m_lr = 0; m_ovf = 0; m_unf = 0; m_last = 8'h80; m_q.delete();
  endtask

  task automatic model_step();
    int sh;
    logic so, su;
    so = 0; su = 0;
`ifdef AUDIO_TX_ATTEN_EN
    sh = int'(atten);
`else
    sh = 0;
`endif
    if (!m_run) begin
      if (enable && m_q.size() > 0) begin m_run = 1; m_rt = 0; end
    end else begin
      m_rt++;
      if (m_rt % (2*CD) == 0) begin
        m_slot = (m_slot + 1) % (2*SW);
        if (m_slot == 0) begin
          m_sd = m_rw[0]; m_lr = 0;
          if (!enable) begin
            m_run = 0; m_slot = 2*SW-1;
          end else begin
            if (m_q.size() > 0) m_last = m_q.pop_front(); else su = 1;
            m_lw = exp_word(m_last, sh); m_rw = m_lw;
          end
        end else begin
          m_lr = (m_slot >= SW);
          m_sd = (m_slot <= SW) ? m_lw[SW-m_slot] : m_rw[2*SW-m_slot];
        end
      end
    end
    if (sample_valid) begin
      if (m_q.size() < DEPTH) m_q.push_back(sample_in); else so = 1;
    end
    if (clear_flags) begin m_ovf = 0; m_unf = 0; end
    else begin m_ovf |= so; m_unf |= su; end
  endtask

  initial model_reset();

  // Compare on the falling clock edge, then advance the model for the
  // coming rising edge using the inputs now stable.
  always @(negedge clock) begin
    if (reset) model_reset();
    a_out = {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, running};
    e_out = {(m_run && ((m_rt / CD) % 2 == 1)), m_lr, m_sd, m_ovf, m_unf, m_run};
    vectors++;
    if (a_out !== e_out) begin
      miscompares++;
      $display("FAIL model t=%0t {bclk,lr,sd,ovf,unf,run}: got %b want %b", $time, a_out, e_out);
    end
    if (!reset) model_step();
  end

  // ---------------- directed helpers ----------------
  task automatic check(string nm, logic [31:0] act, logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic strobe(logic [7:0] s);
    sample_in = s; sample_valid = 1'b1;
    @(posedge clock); #1;
    sample_valid = 1'b0;
  endtask

  task automatic wait_fall(output int n);
    logic p;
    p = i2s_bclk; n = 0;
    repeat (400) begin
      @(posedge clock); #1; n++;
      if (p && !i2s_bclk) return;
      p = i2s_bclk;
    end
    vectors++; miscompares++;
    $display("FAIL wait_fall: no bclk fall in %0d clocks, want one", n);
  endtask

  task automatic collect(input int cnt, output logic [31:0] d, output logic [31:0] l);
    int n;
    d = '0; l = '0;
    for (int i = 0; i < cnt; i++) begin
      wait_fall(n);
      d = {d[30:0], i2s_sdata};
      l = {l[30:0], i2s_lrclk};
    end
  endtask

  task automatic wait_idle();
    repeat (400) begin
      if (!running) return;
      @(posedge clock); #1;
    end
  endtask

  logic [7:0]  burst       [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [31:0] burst_frame [4] = '{32'h9100_9100, 32'hA200_A200, 32'hB300_B300, 32'hC400_C400};

  initial begin
    logic [31:0] d, l, d2;
    int n;
    repeat (2) @(posedge clock); #1;
    check("reset_outputs", {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, running}, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // First sample: latency and frame contents.
    enable = 1'b1;
    strobe(8'hC0);
    wait_fall(n);
    check("first_fall_latency", n, 5);
    strobe(8'h00);
    collect(32, d, l);
    check("frame_c0", d, 32'h4000_4000);
    check("lrclk_slots", l, 32'h0001_FFFE);
    strobe(8'h80);
    collect(32, d, l);
    check("frame_00", d, 32'h8000_8000);
    check("underflow_still_clear", underflow, 0);
    collect(32, d, l);
    check("frame_80", d, 32'h0000_0000);
    check("underflow_on_empty_pop", underflow, 1);

    // Stop, then overflow with five strobes while idle.
    enable = 1'b0; clear_flags = 1'b1;
    @(posedge clock); #1;
    clear_flags = 1'b0;
    wait_idle();
    check("stopped", running, 0);
    check("no_pop_on_stop", underflow, 0);
    for (int i = 0; i < 5; i++) begin
      strobe(burst[i]);
      if (i == 3) check("overflow_at_4", overflow, 0);
      if (i == 4) check("overflow_at_5", overflow, 1);
    end
    clear_flags = 1'b1; enable = 1'b1;
    @(posedge clock); #1;
    clear_flags = 1'b0;
    check("overflow_cleared", overflow, 0);
    wait_fall(n);
    for (int k = 0; k < 4; k++) begin
      collect(32, d, l);
      check("fifo_order_frame", d, burst_frame[k]);
      if (k == 2) check("underflow_before_drain", underflow, 0);
      if (k == 3) check("underflow_after_drain", underflow, 1);
    end
    collect(32, d, l);
    check("repeat_last_sample", d, 32'hC400_C400);

    // Drop enable at slot 10: frame finishes, then idle.
    collect(10, d, l);
    enable = 1'b0;
    collect(22, d, l);
    check("tail_after_drop", d, 32'h0000_C400);
    check("idle_after_drop", running, 0);
    repeat (10) @(posedge clock); #1;
    check("idle_held", {i2s_bclk, running}, 2'b00);

    // Re-enable starts cleanly at slot 0.
    enable = 1'b1;
    strobe(8'h00);
    wait_fall(n);
    check("restart_latency", n, 5);
    collect(32, d, l);
    check("restart_frame", d, 32'h8000_8000);
    check("restart_lrclk", l, 32'h0001_FFFE);

    // Async reset mid-frame at slot 20 with samples queued.
    strobe(8'h33);
    strobe(8'h44);
    collect(20, d, l);
    check("pre_reset_state", {i2s_lrclk, underflow, running}, 3'b111);
    #1 reset = 1'b1;
    #1 check("async_reset", {i2s_bclk, i2s_lrclk, i2s_sdata, overflow, underflow, running}, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (20) @(posedge clock); #1;
    check("fifo_empty_after_reset", running, 0);

`ifdef AUDIO_TX_ATTEN_EN
    atten = 3'd2;
    strobe(8'hC0);
    wait_fall(n);
    collect(5, d, l);
    atten = 3'd0;
    collect(27, d2, l);
    check("atten_frame", (d << 27) | d2, 32'h1000_1000);
    collect(32, d, l);
    check("atten_next_frame", d, 32'h4000_4000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
Name: audio_i2s_tx

Overview:
- Downstream of the music synthesizer. Accepts 8-bit offset-binary audio samples strobed at about 50 kHz and buffers them in a small FIFO.
- Converts each sample to 16-bit two's complement and serializes it as mono (L=R) I2S to the board audio codec.
- Generates BCLK, LRCLK and SDATA from the 50 MHz system clock; no PLL is used.

Parameters:
- CLOCK_DIV, 15: system clocks per BCLK half-period. Default gives BCLK 1.667 MHz and a frame rate of 52.08 kHz.
- SAMPLE_WIDTH, 16: bits per channel slot. A frame is 2*SAMPLE_WIDTH BCLKs.
- FIFO_DEPTH, 4: sample FIFO entries; must be a power of 2, minimum 2.

Ports:
- clock  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high
- enable  in  1  run request
- sample_in  in  8  offset-binary sample (0x80 = silence)
- sample_valid  in  1  one-cycle strobe; sample_in captured this cycle
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  0 = left, 1 = right
- i2s_sdata  out  1  serial data
- overflow  out  1  sticky; sample dropped because FIFO full
- underflow  out  1  sticky; frame started with FIFO empty
- clear_flags  in  1  synchronous clear of overflow/underflow
- running  out  1  FSM in RUN

Behaviour:
- Reset (asynchronous, active-high; clock is clock, reset is reset):
  - Outputs: bclk=0, lrclk=0, sdata=0, overflow=0, underflow=0, running=0.
  - Internal: FIFO empty; current frame = 0; last sample = 0x80; bit_cnt = 2*SAMPLE_WIDTH-1; state IDLE.
- Input and conversion:
  - A sample_valid strobe with FIFO not full writes sample_in.
  - A strobe with FIFO full drops the sample and sets overflow.
  - A simultaneous write and pop on a full FIFO is legal (the pop frees the slot); no overflow.
  - Conversion: word = {sample ^ 8'h80, (SAMPLE_WIDTH-8)'b0}. Frame = {word, word}, 32 bits at default.
- FSM:
  - IDLE: bclk held 0 and divider held 0. Go to RUN when enable=1 and FIFO non-empty.
  - RUN:
    - Divider counts 0..CLOCK_DIV-1; at terminal count bclk toggles.
    - On each bclk falling toggle, bit_cnt advances modulo 2*SAMPLE_WIDTH, giving slot b.
    - lrclk <= (b >= SAMPLE_WIDTH).
    - b==0: sdata <= cur_frame[0] (previous right LSB). In the same cycle cur_frame is loaded from a FIFO pop. If the FIFO is empty, last sample is reused and underflow is set.
    - b>=1: sdata <= cur_frame[2*SAMPLE_WIDTH-b]. This is the standard I2S one-BCLK delay after the LRCLK edge.
  - enable dropped: finish the current frame; on the fall that would enter slot 0, send R LSB, then go to IDLE with bit_cnt = 2*SAMPLE_WIDTH-1. No pop occurs on that fall.
- Timing:
  - All outputs are registered, glitch-free, and change only on the clock edge.
  - Latency from sample_valid into an empty FIFO, with enable high, until the first bclk fall is 2*CLOCK_DIV+1 clocks.
- Flags:
  - clear_flags has priority over a set in the same cycle.
  - running = (state == RUN).
- Rate mismatch: the frame rate exceeds the 50 kHz input rate, so underflow with sample repeat is expected in normal operation and is benign.

Optional Feature:
- AUDIO_TX_ATTEN_EN defined:
  - Adds port atten in 3, a right-shift count.
  - Word is arithmetic-shifted right by atten before framing.
  - atten is sampled at the slot-0 pop only, so a mid-frame change has no effect until the next frame.
- Undefined: no atten port; word passes unshifted.

Decomposition:
- Package audio_pkg:
  - Localparams: CLOCK_FREQ=50000000, default CLOCK_DIV, default SAMPLE_WIDTH.
  - typedef enum logic {IDLE, RUN} i2s_state_t.
  - Function to_signed_word(sample).
- Sub-module sample_fifo: synchronous FIFO with parameterized width/depth, async reset, full/empty flags, and write-and-pop-when-full support. Reused later for the audio sample path.

Test Plan:
- Reset then sample 0xC0 with enable=1, CLOCK_DIV=2: first bclk fall at 5 clocks. Left slot serializes 0x4000 MSB-first starting slot 1; lrclk rises at slot 16; right slot also 0x4000.
- Sample 0x00: word 0x8000, sdata=1 on slot 1 only. Sample 0x80: sdata all 0 for the frame.
- Five strobes with FIFO_DEPTH=4 while enable=0: fifth sets overflow. Enabling then plays four frames in write order; the fifth frame repeats the last sample and sets underflow.
- enable dropped mid-frame at slot 10: remaining slots complete, R LSB goes out at the next fall, then bclk held 0 and running=0. Re-enable starts at slot 0.
- Assert reset at slot 20 of a frame: all outputs and flags return to reset values within the same cycle, asynchronously, and the FIFO is empty.
- With AUDIO_TX_ATTEN_EN and atten=2, sample 0xC0: word 0x1000; changing atten mid-frame alters only the next frame.
